// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback types.
// Optional build macro: WB_FIXED_PRIORITY_EN (consumed by rr_arbiter).
package rf_pkg;

    localparam int N_REGS  = 32;
    localparam int R_WIDTH = 32;
    localparam int W_ADDR  = $clog2(N_REGS);

    // Requester index assignment on the writeback bus
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_MDU = 2'd2,
        WB_FPU = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [W_ADDR-1:0]  addr;
        logic [R_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter for the writeback port.
// Default: round-robin search starting at ptr_i.
// WB_FIXED_PRIORITY_EN: lowest index wins and the pointer input disappears.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int W_IDX = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
`ifndef WB_FIXED_PRIORITY_EN
    input  logic [W_IDX-1:0] ptr_i,
`endif
    output logic [N_REQ-1:0] grant_o,
    output logic [W_IDX-1:0] idx_o,
    output logic             any_o
);

    logic [W_IDX-1:0] j;

    // Scan candidates in priority order; the first valid one takes the grant
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef WB_FIXED_PRIORITY_EN
            j = W_IDX'(k);
`else
            j = W_IDX'((int'(ptr_i) + k) % N_REQ);
`endif
            if (!any_o && valid_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for RegisterFile port 0 with pending-write scoreboard.
// Build macro WB_FIXED_PRIORITY_EN selects fixed priority instead of
// round-robin; the rr pointer register only exists in the default build.
module rf_wb_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int N_REGS  = rf_pkg::N_REGS,
    parameter  int R_WIDTH = rf_pkg::R_WIDTH,
    localparam int W_ADDR  = $clog2(N_REGS),
    localparam int W_IDX   = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*W_ADDR-1:0]    req_addr,
    input  logic [N_REQ*R_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rs0_write,
    output logic [W_ADDR-1:0]          rs0_addr,
    output logic [R_WIDTH-1:0]         rs0_data_in,
    input  logic                       sb_set,
    input  logic [W_ADDR-1:0]          sb_set_addr,
    input  logic [W_ADDR-1:0]          rs1_addr,
    input  logic [W_ADDR-1:0]          rs2_addr,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic                       sb_err
);

    logic [N_REQ-1:0][W_ADDR-1:0]  addr_a;
    logic [N_REQ-1:0][R_WIDTH-1:0] data_a;
    logic [N_REQ-1:0]              valid_g;
    logic [N_REQ-1:0]              grant;
    logic [W_IDX-1:0]              gidx;
    logic                          gany;
    logic [W_ADDR-1:0]             gaddr;
    logic [R_WIDTH-1:0]            gdata;

    logic                          rs0_write_q, rs0_write_d;
    logic [W_ADDR-1:0]             rs0_addr_q, rs0_addr_d;
    logic [R_WIDTH-1:0]            rs0_data_q, rs0_data_d;
    logic [N_REGS-1:0]             busy_q, busy_d;
    logic                          sb_err_q, sb_err_d;
    logic                          set_v;

    assign addr_a  = req_addr;
    assign data_a  = req_data;
    // Reset suppresses all grants so in-flight requests are dropped
    assign valid_g = rst ? '0 : req_valid;

`ifdef WB_FIXED_PRIORITY_EN
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .valid_i (valid_g),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );
`else
    logic [W_IDX-1:0] rr_ptr_q, rr_ptr_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .valid_i (valid_g),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    // Pointer moves just past the winner; holds when idle
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gany)
            rr_ptr_d = (gidx == W_IDX'(N_REQ - 1)) ? '0 : gidx + W_IDX'(1);
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign req_ready = grant;
    assign gaddr     = addr_a[gidx];
    assign gdata     = data_a[gidx];
    assign set_v     = sb_set && (sb_set_addr != '0);

    // Output stage and scoreboard next state; set beats clear on the same reg
    always_comb begin
        rs0_write_d = gany && (gaddr != '0);
        rs0_addr_d  = rs0_addr_q;
        rs0_data_d  = rs0_data_q;
        busy_d      = busy_q;
        sb_err_d    = sb_err_q;
        if (rs0_write_d) begin
            rs0_addr_d = gaddr;
            rs0_data_d = gdata;
        end
        if (gany)  busy_d[gaddr] = 1'b0;
        if (set_v) begin
            busy_d[sb_set_addr] = 1'b1;
            if (busy_q[sb_set_addr]) sb_err_d = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Registered write port and scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            rs0_write_q <= 1'b0;
            rs0_addr_q  <= '0;
            rs0_data_q  <= '0;
            busy_q      <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            rs0_write_q <= rs0_write_d;
            rs0_addr_q  <= rs0_addr_d;
            rs0_data_q  <= rs0_data_d;
            busy_q      <= busy_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign rs0_write   = rs0_write_q;
    assign rs0_addr    = rs0_addr_q;
    assign rs0_data_in = rs0_data_q;
    assign rs1_busy    = (rs1_addr != '0) && busy_q[rs1_addr];
    assign rs2_busy    = (rs2_addr != '0) && busy_q[rs2_addr];
    assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: writes are queued as expected results
// when requests are issued and a negedge monitor checks each rs0 write.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int NR = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NR-1:0]           req_valid;
    logic [NR*W_ADDR-1:0]    req_addr;
    logic [NR*R_WIDTH-1:0]   req_data;
    logic [NR-1:0]           req_ready;
    logic                    rs0_write;
    logic [W_ADDR-1:0]       rs0_addr;
    logic [R_WIDTH-1:0]      rs0_data_in;
    logic                    sb_set;
    logic [W_ADDR-1:0]       sb_set_addr;
    logic [W_ADDR-1:0]       rs1_addr;
    logic [W_ADDR-1:0]       rs2_addr;
    logic                    rs1_busy;
    logic                    rs2_busy;
    logic                    sb_err;

    int      total = 0;
    int      bad   = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;

    logic [R_WIDTH-1:0] regs [N_REGS];
    logic [R_WIDTH-1:0] rd1;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.N_REQ(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rs0_write   (rs0_write),
        .rs0_addr    (rs0_addr),
        .rs0_data_in (rs0_data_in),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .sb_err      (sb_err)
    );

    // Reference register file with write-to-read forwarding on port 1
    always @(posedge clk)
        if (rs0_write && rs0_addr != '0) regs[rs0_addr] <= rs0_data_in;
    assign rd1 = (rs1_addr == '0) ? '0 :
                 (rs0_write && rs0_addr == rs1_addr) ? rs0_data_in : regs[rs1_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W_ADDR-1:0] a,
                           input logic [R_WIDTH-1:0] d);
        req_valid[i] = v;
        req_addr[i*W_ADDR +: W_ADDR]    = a;
        req_data[i*R_WIDTH +: R_WIDTH]  = d;
    endtask

    // Monitor: every port-0 write must match the oldest expected write
    always @(negedge clk) begin
        if (rs0_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got addr %0d data %h expected no write",
                         rs0_addr, rs0_data_in);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_addr", 32'(rs0_addr), 32'(mon_e.addr));
                chk("wb_data", rs0_data_in, mon_e.data);
            end
        end
    end

    initial begin
        int g;
        for (int r = 0; r < N_REGS; r++) regs[r] = '0;
        req_valid = '0; req_addr = '0; req_data = '0;
        sb_set = 1'b0; sb_set_addr = '0; rs1_addr = '0; rs2_addr = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_write", 32'(rs0_write), 32'd0);
        chk("rst_addr",  32'(rs0_addr), 32'd0);
        chk("rst_data",  rs0_data_in, 32'd0);
        chk("rst_err",   32'(sb_err), 32'd0);
        rst = 1'b0;

        // 1: single request from req 1
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("t1_ready", 32'(req_ready), 32'b0010);
        exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
        cyc();
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("t1_write_on", 32'(rs0_write), 32'd1);
        cyc();
        chk("t1_write_off", 32'(rs0_write), 32'd0);
        // bring the pointer round to 0 with a request from req 3
        set_req(3, 1'b1, 5'd6, 32'h00000066);
        #1 chk("t1b_ready", 32'(req_ready), 32'b1000);
        exp_q.push_back('{addr: 5'd6, data: 32'h00000066});
        cyc();
        set_req(3, 1'b0, 5'd0, 32'h0);
        cyc();

        // 2: all four valid continuously
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, W_ADDR'(i + 1), 32'hA0 + i);
        for (int k = 0; k < 5; k++) begin
`ifdef WB_FIXED_PRIORITY_EN
            g = 0;
`else
            g = k % NR;
`endif
            #1 chk("t2_ready", 32'(req_ready), 32'(1 << g));
            exp_q.push_back('{addr: W_ADDR'(g + 1), data: 32'hA0 + g});
            cyc();
        end
        req_valid = '0;
        cyc();

        // 3: write to x0 is consumed but never reaches the port
        set_req(1, 1'b1, 5'd0, 32'h12345678);
        #1 chk("t3_ready", 32'(req_ready), 32'b0010);
        cyc();
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("t3_nowrite", 32'(rs0_write), 32'd0);
        rs1_addr = 5'd0;
        cyc();
        chk("t3_x0_read", rd1, 32'd0);

        // 4: pending reg 7 cleared by req 2 write, forwarded to port 1
        sb_set = 1'b1; sb_set_addr = 5'd7;
        cyc();
        sb_set = 1'b0;
        rs1_addr = 5'd7;
        #1 chk("t4_busy_set", 32'(rs1_busy), 32'd1);
        set_req(2, 1'b1, 5'd7, 32'hCAFEF00D);
        #1 chk("t4_ready", 32'(req_ready), 32'b0100);
        exp_q.push_back('{addr: 5'd7, data: 32'hCAFEF00D});
        cyc();
        set_req(2, 1'b0, 5'd0, 32'h0);
        chk("t4_busy_clr", 32'(rs1_busy), 32'd0);
        chk("t4_fwd_read", rd1, 32'hCAFEF00D);
        cyc();
        chk("t4_reg_read", rd1, 32'hCAFEF00D);

        // 5: set and clear of reg 9 together, then WAW
        sb_set = 1'b1; sb_set_addr = 5'd9;
        set_req(0, 1'b1, 5'd9, 32'h00000099);
        #1 chk("t5_ready", 32'(req_ready), 32'b0001);
        exp_q.push_back('{addr: 5'd9, data: 32'h00000099});
        cyc();
        sb_set = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'h0);
        rs2_addr = 5'd9;
        #1 chk("t5_set_wins", 32'(rs2_busy), 32'd1);
        chk("t5_no_err", 32'(sb_err), 32'd0);
        sb_set = 1'b1;
        cyc();
        sb_set = 1'b0;
        chk("t5_waw_err", 32'(sb_err), 32'd1);
        cyc();
        chk("t5_err_sticky", 32'(sb_err), 32'd1);

        // 6: reset mid-operation
        sb_set = 1'b1; sb_set_addr = 5'd3;
        cyc();
        sb_set = 1'b0;
        rs1_addr = 5'd3;
        #1 chk("t6_busy3", 32'(rs1_busy), 32'd1);
        set_req(0, 1'b1, 5'd10, 32'h0000000A);
        set_req(1, 1'b1, 5'd11, 32'h0000000B);
        set_req(2, 1'b1, 5'd12, 32'h0000000C);
        rst = 1'b1;
        #1 chk("t6_ready_rst", 32'(req_ready), 32'd0);
        cyc();
        chk("t6_write", 32'(rs0_write), 32'd0);
        chk("t6_busy3_clr", 32'(rs1_busy), 32'd0);
        chk("t6_busy9_clr", 32'(rs2_busy), 32'd0);
        chk("t6_err_clr", 32'(sb_err), 32'd0);
        rst = 1'b0;
        #1 chk("t6_first_grant", 32'(req_ready), 32'b0001);
        exp_q.push_back('{addr: 5'd10, data: 32'h0000000A});
        cyc();
        req_valid = '0;

        repeat (3) cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (port 0) among N_REQ writeback requesters, e.g. ALU, LSU, MUL/DIV and FPU, using round-robin arbitration with a valid/ready handshake. Drives the rs0_write, rs0_addr and rs0_data_in inputs of RegisterFile from a registered output stage. Holds a per-register pending-write scoreboard, so issue logic can stall reads of registers with an outstanding multi-cycle result.

Parameters:
N_REQ, 4, number of writeback requesters (2..8)
N_REGS, 32, number of architectural registers
R_WIDTH, 32, register data width
W_ADDR, $clog2(N_REGS), register address width (localparam)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  requester i has a result to write
req_addr  in  N_REQ*W_ADDR  destination register, requester i in slice i
req_data  in  N_REQ*R_WIDTH  result data, requester i in slice i
req_ready  out  N_REQ  one-hot grant; a transfer occurs when valid&ready
rs0_write  out  1  write enable to RegisterFile port 0 (registered)
rs0_addr  out  W_ADDR  write address (registered)
rs0_data_in  out  R_WIDTH  write data (registered)
sb_set  in  1  issue stage marks a register as pending
sb_set_addr  in  W_ADDR  register to mark pending
rs1_addr  in  W_ADDR  query address for read port 1
rs2_addr  in  W_ADDR  query address for read port 2
rs1_busy  out  1  rs1_addr has a pending write (combinational)
rs2_busy  out  1  rs2_addr has a pending write (combinational)
sb_err  out  1  sticky: sb_set hit an already-busy register

Behaviour:
- Reset values, applied at the first rising edge with rst=1:
  - rs0_write=0, rs0_addr=0, rs0_data_in=0.
  - rr_ptr=0, busy[N_REGS-1:0]=0, sb_err=0.
  - While rst=1, req_ready is forced to 0 and sb_set is ignored.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo N_REQ.
  - The first valid index g gets req_ready[g]=1. All other ready bits are 0.
  - At most one grant per cycle. No valid requests means no grant.
  - req_ready never depends on the requester's own ready; there is no combinational loop.
- Pointer update: on a grant, rr_ptr <= (g+1) mod N_REQ. With no grant, rr_ptr holds.
- Handshake:
  - A requester holds valid, addr and data stable until it sees ready=1.
  - It may drop valid only after the transfer.
- Output stage latency:
  - The granted request appears on the rs0_* outputs one cycle after the grant edge.
  - rs0_write=1 for exactly one cycle per grant.
  - With no grant, rs0_write=0 and rs0_addr/rs0_data_in hold their last values.
- Writes to x0:
  - A request with addr=0 is granted and consumed normally.
  - rs0_write stays 0 for it; the data is discarded.
- Scoreboard:
  - sb_set=1 with sb_set_addr!=0 sets busy[sb_set_addr] at the next edge. sb_set_addr=0 is ignored.
  - A grant with addr a clears busy[a] at the grant edge.
  - One cycle later the write is on port 0, and RegisterFile forwarding, which must be enabled, supplies the data to a same-cycle reader.
  - Simultaneous set and clear of the same address: set wins and busy stays 1, because a new producer is pending.
  - sb_set on an already-busy register (WAW): busy stays 1 and sb_err <= 1, sticky until rst. Issue logic must stall on rd busy.
  - rsN_busy = busy[rsN_addr]. busy[0] always reads 0.
- Reset mid-operation:
  - In-flight requests are dropped and no grant is issued.
  - The output register and all busy bits clear at the reset edge.

Optional Feature:
WB_FIXED_PRIORITY_EN
- Defined: fixed priority, lowest index wins; rr_ptr is removed.
- Not defined: round-robin as above.
- Handshake, latency and scoreboard behaviour are identical in both builds.

Decomposition:
- Package rf_pkg holds:
  - Constants N_REGS, R_WIDTH, W_ADDR.
  - Enum wb_src_e {WB_ALU=0, WB_LSU=1, WB_MDU=2, WB_FPU=3} for requester indices.
  - Typedef wb_req_t struct {addr, data}.
- One sub-module, rr_arbiter (parameter N_REQ): valid vector and pointer in, one-hot grant and index out. The fixed-priority variant is selected inside it by the macro.

Test Plan:
1. Single request: req 1 valid, addr=5, data=32'hDEADBEEF. req_ready=4'b0010 in the same cycle; next cycle rs0_write=1, rs0_addr=5, rs0_data_in=DEADBEEF, then rs0_write=0.
2. All four valid continuously, addr=i+1. Grants follow the order 0,1,2,3,0; one rs0_write per cycle; no requester starved. With WB_FIXED_PRIORITY_EN, req 0 wins every cycle while it is valid.
3. Request addr=0, data=32'h12345678: it is granted, rs0_write stays 0, and x0 reads 0 afterwards.
4. sb_set addr=7, then rs1_addr=7: rs1_busy=1. Req 2 writes addr 7: rs1_busy=0 from the cycle after the grant, and the port-1 read returns the written data via forwarding.
5. sb_set addr=9 and a grant of addr=9 in the same cycle: busy[9]=1 afterwards. A second sb_set addr=9 gives sb_err=1.
6. rst asserted while 3 requests are valid and busy[3]=1: req_ready=0 during reset; after the reset edge rs0_write=0, busy[3]=0 and sb_err=0, and the first grant after release is index 0.
